lcd_timing_gen: RTL and testbench

Parametrised RGB LCD timing generator. It produces HS/VS/DE and an RGB565 data bus from one pixel clock, and supports a configurable pixel-source latency (`REQ_LEAD`). Sync mode is selectable: DE-only, or separate HS/VS with programmable polarity. A `display` enable takes effect only on frame boundaries. The block sits between the frame-buffer/overlay pixel source and the LCD pins, replacing the fixed 800x480 driver.

---
 rtl/lcd_timing_gen_if.sv | 31 +++
 rtl/lcd_timing_gen.sv | 141 ++++++++++++++
 tb/tb_lcd_timing_gen.sv | 320 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lcd_timing_gen_if.sv
// Pixel-source and panel-side signal bundle for the LCD timing generator.
// The generator uses the master view; the pixel source / panel model uses the slave view.
interface lcd_timing_gen_if #(
    parameter int unsigned CW = 12
) ();
    logic          display;
    logic [15:0]   pixel_data;
    logic          data_req;
    logic [CW-1:0] pixel_xpos;
    logic [CW-1:0] pixel_ypos;
    logic          frame_start;
    logic          lcd_hs;
    logic          lcd_vs;
    logic          lcd_de;
    logic [15:0]   lcd_rgb;
    logic          lcd_bl;
    logic          lcd_rst;
    logic          lcd_pclk;

    modport master (
        input  display, pixel_data,
        output data_req, pixel_xpos, pixel_ypos, frame_start,
        output lcd_hs, lcd_vs, lcd_de, lcd_rgb, lcd_bl, lcd_rst, lcd_pclk
    );

    modport slave (
        output display, pixel_data,
        input  data_req, pixel_xpos, pixel_ypos, frame_start,
        input  lcd_hs, lcd_vs, lcd_de, lcd_rgb, lcd_bl, lcd_rst, lcd_pclk
    );
endinterface

// File: rtl/lcd_timing_gen.sv
// Parametrised RGB LCD timing generator: pixel requests with coordinates, then HS/VS/DE
// and RGB565 delayed by REQ_LEAD cycles to absorb the pixel source latency.
module lcd_timing_gen #(
    parameter int unsigned H_SYNC   = 128,
    parameter int unsigned H_BACK   = 88,
    parameter int unsigned H_DISP   = 800,
    parameter int unsigned H_FRONT  = 40,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BACK   = 33,
    parameter int unsigned V_DISP   = 480,
    parameter int unsigned V_FRONT  = 10,
    parameter int unsigned CW       = 12,
    parameter int unsigned REQ_LEAD = 1,
    parameter int unsigned MODE     = 0,
    parameter bit          HS_POL   = 1'b0,
    parameter bit          VS_POL   = 1'b0
) (
    input logic              lcd_clk,
    input logic              sys_rst,
    lcd_timing_gen_if.master bus
);
    localparam int unsigned H_TOTAL  = H_SYNC + H_BACK + H_DISP + H_FRONT;
    localparam int unsigned V_TOTAL  = V_SYNC + V_BACK + V_DISP + V_FRONT;
    localparam int unsigned H_ACT_LO = H_SYNC + H_BACK;
    localparam int unsigned H_ACT_HI = H_ACT_LO + H_DISP;
    localparam int unsigned V_ACT_LO = V_SYNC + V_BACK;
    localparam int unsigned V_ACT_HI = V_ACT_LO + V_DISP;
    localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);

    logic [CW-1:0]     r_cnt_h;
    logic [CW-1:0]     r_cnt_v;
    logic              r_en_frame;
    logic              r_data_req;
    logic [CW-1:0]     r_xpos;
    logic [CW-1:0]     r_ypos;
    logic              r_frame_start;
    logic              r_hs0;
    logic              r_vs0;
    logic [REQ_LEAD-1:0] r_act_sr;
    logic [REQ_LEAD-1:0] r_hs_sr;
    logic [REQ_LEAD-1:0] r_vs_sr;
    logic [15:0]       r_rgb;

    // Counters widened to 32 bits so range limits equal to 2^CW still compare correctly.
    logic [31:0]       w_h;
    logic [31:0]       w_v;
    logic              w_h_last;
    logic              w_v_last;
    logic              w_act;
    // Index i of each chain is the stage-0 value delayed by i cycles.
    logic [REQ_LEAD:0] w_act_chain;
    logic [REQ_LEAD:0] w_hs_chain;
    logic [REQ_LEAD:0] w_vs_chain;

    assign w_h      = 32'(r_cnt_h);
    assign w_v      = 32'(r_cnt_v);
    assign w_h_last = (r_cnt_h == H_LAST);
    assign w_v_last = (r_cnt_v == V_LAST);
    assign w_act    = r_en_frame && (w_h >= H_ACT_LO) && (w_h < H_ACT_HI)
                      && (w_v >= V_ACT_LO) && (w_v < V_ACT_HI);

    assign w_act_chain = {r_act_sr, r_data_req};
    assign w_hs_chain  = {r_hs_sr, r_hs0};
    assign w_vs_chain  = {r_vs_sr, r_vs0};

    // Horizontal/vertical position counters, wrapping with no idle cycle.
    always_ff @(posedge lcd_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_cnt_h <= '0;
            r_cnt_v <= '0;
        end else if (w_h_last) begin
            r_cnt_h <= '0;
            r_cnt_v <= w_v_last ? '0 : r_cnt_v + 1'b1;
        end else begin
            r_cnt_h <= r_cnt_h + 1'b1;
        end
    end

    // Display enable only changes on the last pixel of a frame.
    always_ff @(posedge lcd_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_en_frame <= 1'b0;
        end else if (w_h_last && w_v_last) begin
            r_en_frame <= bus.display;
        end
    end

    // Stage 0: request, coordinates, frame pulse and raw sync levels.
    always_ff @(posedge lcd_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_data_req    <= 1'b0;
            r_xpos        <= '0;
            r_ypos        <= '0;
            r_frame_start <= 1'b0;
            r_hs0         <= 1'b0;
            r_vs0         <= 1'b0;
        end else begin
            r_data_req    <= w_act;
            r_xpos        <= w_act ? CW'(w_h - H_ACT_LO) : '0;
            r_ypos        <= w_act ? CW'(w_v - V_ACT_LO) : '0;
            r_frame_start <= (r_cnt_h == '0) && (r_cnt_v == '0);
            r_hs0         <= (w_h < H_SYNC);
            r_vs0         <= (w_v < V_SYNC);
        end
    end

    // REQ_LEAD-deep delay line carrying {act, hs, vs} to the panel pins.
    always_ff @(posedge lcd_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_act_sr <= '0;
            r_hs_sr  <= '0;
            r_vs_sr  <= '0;
        end else begin
            r_act_sr <= w_act_chain[REQ_LEAD-1:0];
            r_hs_sr  <= w_hs_chain[REQ_LEAD-1:0];
            r_vs_sr  <= w_vs_chain[REQ_LEAD-1:0];
        end
    end

    // Capture pixel data on the same edge that raises DE, so RGB is 0 whenever DE is 0.
    always_ff @(posedge lcd_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_rgb <= '0;
        end else begin
            r_rgb <= w_act_chain[REQ_LEAD-1] ? bus.pixel_data : 16'h0000;
        end
    end

    assign bus.data_req    = r_data_req;
    assign bus.pixel_xpos  = r_xpos;
    assign bus.pixel_ypos  = r_ypos;
    assign bus.frame_start = r_frame_start;
    assign bus.lcd_de      = r_act_sr[REQ_LEAD-1];
    assign bus.lcd_hs      = (MODE == 1) ? (r_hs_sr[REQ_LEAD-1] ? HS_POL : ~HS_POL) : 1'b1;
    assign bus.lcd_vs      = (MODE == 1) ? (r_vs_sr[REQ_LEAD-1] ? VS_POL : ~VS_POL) : 1'b1;
    assign bus.lcd_rgb     = r_rgb;
    assign bus.lcd_bl      = 1'b1;
    assign bus.lcd_rst     = ~sys_rst;
    assign bus.lcd_pclk    = lcd_clk;
endmodule

// File: tb/tb_lcd_timing_gen.sv
// Bench for lcd_timing_gen: three small-geometry instances (lead 1 / lead 3 with inverted
// polarity / DE-only mode) checked every cycle against a position-from-cycle-count model.
module tb_lcd_timing_gen;
    localparam int HS_W = 4, HB = 2, HD = 8, HF = 2;
    localparam int VS_W = 1, VB = 1, VD = 4, VF = 1;
    localparam int HT   = HS_W + HB + HD + HF;
    localparam int VT   = VS_W + VB + VD + VF;
    localparam int FR   = HT * VT;
    localparam int unsigned CW = 12;
    localparam int LA = 1, LB = 3, LC = 2;
    localparam int HIST = 64;

    logic lcd_clk = 1'b0;
    logic sys_rst = 1'b1;
    logic display = 1'b1;

    always #5 lcd_clk = ~lcd_clk;

    lcd_timing_gen_if #(.CW(CW)) if_a ();
    lcd_timing_gen_if #(.CW(CW)) if_b ();
    lcd_timing_gen_if #(.CW(CW)) if_c ();

    assign if_a.display = display;
    assign if_b.display = display;
    assign if_c.display = display;

    lcd_timing_gen #(
        .H_SYNC(HS_W), .H_BACK(HB), .H_DISP(HD), .H_FRONT(HF),
        .V_SYNC(VS_W), .V_BACK(VB), .V_DISP(VD), .V_FRONT(VF),
        .CW(CW), .REQ_LEAD(LA), .MODE(1), .HS_POL(1'b0), .VS_POL(1'b0)
    ) dut_a (.lcd_clk(lcd_clk), .sys_rst(sys_rst), .bus(if_a));

    lcd_timing_gen #(
        .H_SYNC(HS_W), .H_BACK(HB), .H_DISP(HD), .H_FRONT(HF),
        .V_SYNC(VS_W), .V_BACK(VB), .V_DISP(VD), .V_FRONT(VF),
        .CW(CW), .REQ_LEAD(LB), .MODE(1), .HS_POL(1'b1), .VS_POL(1'b1)
    ) dut_b (.lcd_clk(lcd_clk), .sys_rst(sys_rst), .bus(if_b));

    lcd_timing_gen #(
        .H_SYNC(HS_W), .H_BACK(HB), .H_DISP(HD), .H_FRONT(HF),
        .V_SYNC(VS_W), .V_BACK(VB), .V_DISP(VD), .V_FRONT(VF),
        .CW(CW), .REQ_LEAD(LC), .MODE(0), .HS_POL(1'b0), .VS_POL(1'b0)
    ) dut_c (.lcd_clk(lcd_clk), .sys_rst(sys_rst), .bus(if_c));

    // k = rising edges since reset release; interval k sees counter position k mod FR.
    int k;
    bit m_en;
    bit act_h [HIST];
    bit hs_h [HIST];
    bit vs_h [HIST];
    int x_h [HIST];
    int y_h [HIST];
    logic [15:0] pda_h [HIST];
    logic [15:0] pdc_h [HIST];
    int n_checks;
    int n_fail;
    int req_cnt;

    function automatic bit act_at(int j);
        if (j < 0) return 1'b0;
        return act_h[j % HIST];
    endfunction
    function automatic bit hs_at(int j);
        if (j < 0) return 1'b0;
        return hs_h[j % HIST];
    endfunction
    function automatic bit vs_at(int j);
        if (j < 0) return 1'b0;
        return vs_h[j % HIST];
    endfunction
    function automatic int x_at(int j);
        if (j < 0) return 0;
        return x_h[j % HIST];
    endfunction
    function automatic int y_at(int j);
        if (j < 0) return 0;
        return y_h[j % HIST];
    endfunction
    function automatic logic [15:0] pda_at(int j);
        if (j < 0) return 16'h0;
        return pda_h[j % HIST];
    endfunction
    function automatic logic [15:0] pdc_at(int j);
        if (j < 0) return 16'h0;
        return pdc_h[j % HIST];
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s k=%0d got=%0h expected=%0h", tag, k, got, exp);
        end
    endtask

    // Model of interval k from the frame geometry alone.
    task automatic record_interval();
        int p, h, v;
        bit a;
        p = k % FR;
        h = p % HT;
        v = p / HT;
        a = m_en && (h >= HS_W + HB) && (h < HS_W + HB + HD)
            && (v >= VS_W + VB) && (v < VS_W + VB + VD);
        act_h[k % HIST] = a;
        x_h[k % HIST]   = a ? h - (HS_W + HB) : 0;
        y_h[k % HIST]   = a ? v - (VS_W + VB) : 0;
        hs_h[k % HIST]  = (h < HS_W);
        vs_h[k % HIST]  = (v < VS_W);
    endtask

    task automatic drive_inputs();
        int j;
        pda_h[k % HIST] = 16'($urandom);
        pdc_h[k % HIST] = 16'($urandom);
        if_a.pixel_data = pda_h[k % HIST];
        if_c.pixel_data = pdc_h[k % HIST];
        // Source for B answers the request seen LB-1 cycles ago with {y, x}.
        j = k - LB;
        if (act_at(j)) if_b.pixel_data = {8'(y_at(j)), 8'(x_at(j))};
        else if_b.pixel_data = 16'hdead;
    endtask

    task automatic check_dut(input string nm, input int lead, input int mode, input bit hp,
                             input bit vp, input logic req, input logic [CW-1:0] xp,
                             input logic [CW-1:0] yp, input logic fs, input logic hs,
                             input logic vs, input logic de, input logic [15:0] rgb,
                             input logic bl, input logic prst, input logic [15:0] exp_rgb);
        int j0, jl;
        bit e_req, e_hs, e_vs;
        j0 = k - 1;
        jl = k - 1 - lead;
        e_req = act_at(j0);
        e_hs = (mode == 1) ? (hs_at(jl) ? hp : !hp) : 1'b1;
        e_vs = (mode == 1) ? (vs_at(jl) ? vp : !vp) : 1'b1;
        check_eq({nm, ".data_req"}, 32'(req), 32'(e_req));
        check_eq({nm, ".xpos"}, 32'(xp), e_req ? 32'(x_at(j0)) : 32'd0);
        check_eq({nm, ".ypos"}, 32'(yp), e_req ? 32'(y_at(j0)) : 32'd0);
        check_eq({nm, ".frame_start"}, 32'(fs), 32'((k >= 1) && (j0 % FR == 0)));
        check_eq({nm, ".de"}, 32'(de), 32'(act_at(jl)));
        check_eq({nm, ".hs"}, 32'(hs), 32'(e_hs));
        check_eq({nm, ".vs"}, 32'(vs), 32'(e_vs));
        check_eq({nm, ".rgb"}, 32'(rgb), 32'(exp_rgb));
        check_eq({nm, ".bl"}, 32'(bl), 32'd1);
        check_eq({nm, ".lcd_rst"}, 32'(prst), 32'd1);
    endtask

    task automatic check_outputs();
        int ja, jb, jc;
        logic [15:0] ea, eb, ec;
        ja = k - 1 - LA;
        jb = k - 1 - LB;
        jc = k - 1 - LC;
        ea = act_at(ja) ? pda_at(k - 1) : 16'h0;
        eb = act_at(jb) ? {8'(y_at(jb)), 8'(x_at(jb))} : 16'h0;
        ec = act_at(jc) ? pdc_at(k - 1) : 16'h0;
        check_dut("a", LA, 1, 1'b0, 1'b0, if_a.data_req, if_a.pixel_xpos, if_a.pixel_ypos,
                  if_a.frame_start, if_a.lcd_hs, if_a.lcd_vs, if_a.lcd_de, if_a.lcd_rgb,
                  if_a.lcd_bl, if_a.lcd_rst, ea);
        check_dut("b", LB, 1, 1'b1, 1'b1, if_b.data_req, if_b.pixel_xpos, if_b.pixel_ypos,
                  if_b.frame_start, if_b.lcd_hs, if_b.lcd_vs, if_b.lcd_de, if_b.lcd_rgb,
                  if_b.lcd_bl, if_b.lcd_rst, eb);
        check_dut("c", LC, 0, 1'b0, 1'b0, if_c.data_req, if_c.pixel_xpos, if_c.pixel_ypos,
                  if_c.frame_start, if_c.lcd_hs, if_c.lcd_vs, if_c.lcd_de, if_c.lcd_rgb,
                  if_c.lcd_bl, if_c.lcd_rst, ec);
        check_eq("a.pclk", 32'(if_a.lcd_pclk), 32'(lcd_clk));
    endtask

    task automatic chk_rst(input string nm, input int mode, input bit hp, input bit vp,
                           input logic req, input logic [CW-1:0] xp, input logic [CW-1:0] yp,
                           input logic fs, input logic hs, input logic vs, input logic de,
                           input logic [15:0] rgb, input logic prst);
        check_eq({nm, ".rst_req"}, 32'(req), 32'd0);
        check_eq({nm, ".rst_xpos"}, 32'(xp), 32'd0);
        check_eq({nm, ".rst_ypos"}, 32'(yp), 32'd0);
        check_eq({nm, ".rst_fs"}, 32'(fs), 32'd0);
        check_eq({nm, ".rst_de"}, 32'(de), 32'd0);
        check_eq({nm, ".rst_rgb"}, 32'(rgb), 32'd0);
        check_eq({nm, ".rst_hs"}, 32'(hs), (mode == 1) ? 32'(!hp) : 32'd1);
        check_eq({nm, ".rst_vs"}, 32'(vs), (mode == 1) ? 32'(!vp) : 32'd1);
        check_eq({nm, ".rst_lcd_rst"}, 32'(prst), 32'd0);
    endtask

    task automatic check_reset_values();
        chk_rst("a", 1, 1'b0, 1'b0, if_a.data_req, if_a.pixel_xpos, if_a.pixel_ypos,
                if_a.frame_start, if_a.lcd_hs, if_a.lcd_vs, if_a.lcd_de, if_a.lcd_rgb,
                if_a.lcd_rst);
        chk_rst("b", 1, 1'b1, 1'b1, if_b.data_req, if_b.pixel_xpos, if_b.pixel_ypos,
                if_b.frame_start, if_b.lcd_hs, if_b.lcd_vs, if_b.lcd_de, if_b.lcd_rgb,
                if_b.lcd_rst);
        chk_rst("c", 0, 1'b0, 1'b0, if_c.data_req, if_c.pixel_xpos, if_c.pixel_ypos,
                if_c.frame_start, if_c.lcd_hs, if_c.lcd_vs, if_c.lcd_de, if_c.lcd_rgb,
                if_c.lcd_rst);
    endtask

    task automatic step();
        @(posedge lcd_clk);
        if (k % FR == FR - 1) m_en = display;
        k++;
        record_interval();
        #1;
        check_outputs();
        if (if_a.data_req === 1'b1) req_cnt++;
        drive_inputs();
    endtask

    // Expects sys_rst already high; releases it between edges and restarts the model.
    task automatic release_reset();
        repeat (2) @(posedge lcd_clk);
        @(negedge lcd_clk);
        check_reset_values();
        sys_rst = 1'b0;
        k = 0;
        m_en = 1'b0;
        for (int i = 0; i < HIST; i++) begin
            act_h[i] = 1'b0;
            hs_h[i] = 1'b0;
            vs_h[i] = 1'b0;
            x_h[i] = 0;
            y_h[i] = 0;
        end
        record_interval();
        #1;
        check_outputs();
        drive_inputs();
    endtask

    task automatic sync_frame();
        for (int i = 0; i < FR && (k % FR) != 0; i++) step();
    endtask

    initial begin
        int bursts, hs_lo, vs_lo, fs_cnt;
        logic prev;
        n_checks = 0;
        n_fail = 0;
        req_cnt = 0;
        k = 0;
        m_en = 1'b0;
        if_a.pixel_data = 16'h0;
        if_b.pixel_data = 16'h0;
        if_c.pixel_data = 16'h0;
        #12;
        release_reset();

        // First frame blank, second frame 32 requests in 4 bursts.
        repeat (FR) step();
        check_eq("frame0_req_count", 32'(req_cnt), 32'd0);
        req_cnt = 0;
        bursts = 0;
        hs_lo = 0;
        vs_lo = 0;
        fs_cnt = 0;
        prev = 1'b0;
        for (int i = 0; i < FR; i++) begin
            step();
            if (if_a.data_req && !prev) bursts++;
            prev = if_a.data_req;
            if (!if_a.lcd_hs) hs_lo++;
            if (!if_a.lcd_vs) vs_lo++;
            if (if_a.frame_start) fs_cnt++;
        end
        check_eq("frame1_req_count", 32'(req_cnt), 32'(HD * VD));
        check_eq("frame1_bursts", 32'(bursts), 32'(VD));
        check_eq("frame1_hs_low", 32'(hs_lo), 32'(HS_W * VT));
        check_eq("frame1_vs_low", 32'(vs_lo), 32'(VS_W * HT));
        check_eq("frame1_fs_pulses", 32'(fs_cnt), 32'd1);
        repeat (FR) step();

        // Drop display mid-frame: this frame completes, the next is blank.
        sync_frame();
        req_cnt = 0;
        for (int i = 0; i < FR && ((k % FR) / HT) != 3; i++) step();
        display = 1'b0;
        sync_frame();
        check_eq("drop_frame_req", 32'(req_cnt), 32'(HD * VD));
        req_cnt = 0;
        repeat (FR) step();
        check_eq("off_frame_req", 32'(req_cnt), 32'd0);
        // Raise display mid-frame: pixels resume one frame later.
        req_cnt = 0;
        repeat ($urandom_range(5, FR - 5)) step();
        display = 1'b1;
        sync_frame();
        check_eq("raise_frame_req", 32'(req_cnt), 32'd0);
        req_cnt = 0;
        repeat (FR) step();
        check_eq("resume_frame_req", 32'(req_cnt), 32'(HD * VD));

        // Random display toggling.
        for (int i = 0; i < 1500; i++) begin
            step();
            if ($urandom_range(0, 39) == 0) display = ~display;
        end

        // Reset asserted during an active pixel, then a blank restart.
        display = 1'b1;
        for (int r = 0; r < 3; r++) begin
            bit found;
            repeat (2 * FR + $urandom_range(0, 40)) step();
            found = act_at(k - 1);
            for (int i = 0; i < 2 * FR && !found; i++) begin
                step();
                found = act_at(k - 1);
            end
            check_eq("found_active_pixel", 32'(found), 32'd1);
            #2;
            sys_rst = 1'b1;
            #1;
            check_reset_values();
            release_reset();
            req_cnt = 0;
            repeat (FR) step();
            check_eq("blank_after_reset", 32'(req_cnt), 32'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
